// File: rtl/rvvi_depacketizer.sv
// Reassembles one RVVI record per Ethernet frame from a 32-bit stream; optional RVVI_DEPKT_SEQCHK_EN adds sequence checking.
// Latency: record Valid one cycle after the last beat. Backpressure: RvviAxiRready low while a record is held.
module rvvi_depacketizer #(
    parameter int XLEN              = 64,
    parameter int MAX_CSRS          = 5,
    parameter int RVVI_WIDTH        = 128 + 4*XLEN + MAX_CSRS*(XLEN+16),
    parameter int ETH_HEADER_WIDTH  = 112,
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input  logic                         m_axi_aclk,
    input  logic                         m_axi_aresetn,
    input  logic [31:0]                  RvviAxiRdata,
    input  logic [3:0]                   RvviAxiRstrb,
    input  logic                         RvviAxiRlast,
    input  logic                         RvviAxiRvalid,
    output logic                         RvviAxiRready,
    input  logic [47:0]                  LocalMac,
    input  logic [15:0]                  EthType,
    output logic                         Valid,
    input  logic                         Ready,
    output logic [RVVI_WIDTH-1:0]        Rvvi,
    output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
    output logic [47:0]                  SrcMac,
    output logic [15:0]                  RuntCount,
    output logic [15:0]                  BadHdrCount
`ifdef RVVI_DEPKT_SEQCHK_EN
    ,
    output logic                         SeqErr,
    output logic [15:0]                  SeqErrCount
`endif
);
    localparam int FW = ETH_HEADER_WIDTH + FRAME_COUNT_WIDTH + RVVI_WIDTH;
    localparam int NW = (FW + 31) / 32;
    localparam int CW = $clog2(NW + 1);

    localparam logic [0:0] RECV = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   bad_q, bad_d;
    logic                   rdy_q;
    logic [FW-1:0]          buf_q;
    logic [NW*32-1:0]       f_cur;
    logic                   beat_acc, hdr_bad, bad_now, good_end, runt_end, bad_end;
    logic                   unused_bits;

    assign RvviAxiRready = rdy_q;
    assign Valid         = (state_q == HOLD);
    assign beat_acc      = RvviAxiRvalid & rdy_q & (state_q == RECV);

    // Frame image as it will look once the current beat is written.
    always_comb begin
        f_cur = {{(NW*32-FW){1'b0}}, buf_q};
        for (int w = 0; w < NW; w++) begin
            if (cnt_q == CW'(w)) f_cur[w*32 +: 32] = RvviAxiRdata;
        end
    end

    assign hdr_bad  = (f_cur[47:0] != LocalMac) |
                      (f_cur[ETH_HEADER_WIDTH-1 -: 16] != EthType);
    assign bad_now  = bad_q | ((cnt_q == CW'(3)) & hdr_bad);
    assign bad_end  = beat_acc & RvviAxiRlast & bad_now;
    assign good_end = beat_acc & RvviAxiRlast & ~bad_now & (cnt_q >= CW'(NW-1));
    assign runt_end = beat_acc & RvviAxiRlast & ~bad_now & (cnt_q <  CW'(NW-1));

    assign unused_bits = ^{RvviAxiRstrb, f_cur[NW*32-1:FW]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        if (state_q == RECV) begin
            if (beat_acc) begin
                if (RvviAxiRlast) begin
                    cnt_d = '0;
                    bad_d = 1'b0;
                    if (good_end) state_d = HOLD;
                end else begin
                    if (cnt_q < CW'(NW)) cnt_d = cnt_q + CW'(1);
                    bad_d = bad_now;
                end
            end
        end else if (Ready) begin
            state_d = RECV;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= RECV;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            rdy_q       <= 1'b0;
            buf_q       <= '0;
            Rvvi        <= '0;
            FrameCount  <= '0;
            SrcMac      <= '0;
            RuntCount   <= '0;
            BadHdrCount <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            rdy_q   <= (state_d == RECV);
            if (beat_acc) buf_q <= f_cur[FW-1:0];
            if (good_end) begin
                Rvvi       <= f_cur[FW-1 -: RVVI_WIDTH];
                FrameCount <= f_cur[ETH_HEADER_WIDTH +: FRAME_COUNT_WIDTH];
                SrcMac     <= f_cur[95:48];
            end
            if (runt_end && RuntCount != 16'hFFFF)  RuntCount   <= RuntCount + 16'd1;
            if (bad_end && BadHdrCount != 16'hFFFF) BadHdrCount <= BadHdrCount + 16'd1;
        end
    end

`ifdef RVVI_DEPKT_SEQCHK_EN
    logic [FRAME_COUNT_WIDTH-1:0] exp_q;
    logic [FRAME_COUNT_WIDTH-1:0] fc_in;

    assign fc_in = f_cur[ETH_HEADER_WIDTH +: FRAME_COUNT_WIDTH];

    // SeqErr is registered on the same edge that raises Valid.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            exp_q       <= '0;
            SeqErr      <= 1'b0;
            SeqErrCount <= '0;
        end else begin
            SeqErr <= 1'b0;
            if (good_end) begin
                exp_q <= fc_in + FRAME_COUNT_WIDTH'(1);
                if (fc_in != exp_q) begin
                    SeqErr <= 1'b1;
                    if (SeqErrCount != 16'hFFFF) SeqErrCount <= SeqErrCount + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer: builds frame images, streams them and checks records and counters.
module tb_rvvi_depacketizer;
    localparam int RW = 784;
    localparam int FW = 912;
    localparam int NW = 29;
    localparam int IW = NW * 32;

    localparam logic [47:0] LMAC = 48'h0A1B2C3D4E5F;
    localparam logic [47:0] SRC1 = 48'h112233445566;
    localparam logic [47:0] SRC2 = 48'hA0B0C0D0E0F0;
    localparam logic [15:0] ET   = 16'h88B5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   rdata = '0;
    logic [3:0]    rstrb = 4'hF;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic          valid;
    logic          ready = 1'b1;
    logic [RW-1:0] rvvi;
    logic [15:0]   frame_count;
    logic [47:0]   src_mac;
    logic [15:0]   runt_count;
    logic [15:0]   bad_count;
`ifdef RVVI_DEPKT_SEQCHK_EN
    logic          seq_err;
    logic [15:0]   seq_err_count;
`endif

    int checks = 0;
    int passed = 0;
    logic [IW-1:0] img, img2;

    always #5 clk = ~clk;

    rvvi_depacketizer dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .RvviAxiRdata  (rdata),
        .RvviAxiRstrb  (rstrb),
        .RvviAxiRlast  (rlast),
        .RvviAxiRvalid (rvalid),
        .RvviAxiRready (rready),
        .LocalMac      (LMAC),
        .EthType       (ET),
        .Valid         (valid),
        .Ready         (ready),
        .Rvvi          (rvvi),
        .FrameCount    (frame_count),
        .SrcMac        (src_mac),
        .RuntCount     (runt_count),
        .BadHdrCount   (bad_count)
`ifdef RVVI_DEPKT_SEQCHK_EN
        ,
        .SeqErr        (seq_err),
        .SeqErrCount   (seq_err_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [IW-1:0] mk_img(input logic [47:0] dst, input logic [47:0] src,
                                             input logic [15:0] et, input logic [15:0] fc,
                                             input logic [7:0] seed);
        logic [IW-1:0] f;
        f = '0;
        for (int w = 4; w < NW; w++) f[w*32 +: 32] = {seed, 8'(w), 16'h5A00 ^ 16'(w*7)};
        f[47:0]    = dst;
        f[95:48]   = src;
        f[111:96]  = et;
        f[127:112] = fc;
        return f;
    endfunction

    // Drive one beat at #1 after an edge; it is taken at the first edge that sees Rready.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        rvalid = 1'b1;
        rdata  = d;
        rlast  = l;
        n = 0;
        while (!rready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) begin
            checks++;
            $display("FAIL beat_timeout: Rready stayed %0b, expected 1 within 50 cycles", rready);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [IW-1:0] f, input int first, input int nb, input bit end_last);
        for (int b = first; b < nb; b++) begin
            if (b < NW) send_beat(f[b*32 +: 32], end_last && (b == nb-1));
            else        send_beat(32'hDEAD0000 | 32'(b), end_last && (b == nb-1));
        end
    endtask

`ifdef RVVI_DEPKT_SEQCHK_EN
    logic [15:0] seq_fc  [6] = '{16'h0000, 16'h0001, 16'h0003, 16'h0004, 16'hFFFF, 16'h0000};
    logic        seq_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif

    initial begin
        #1;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_runt", 64'(runt_count), 64'd0);
        chk("rst_bad", 64'(bad_count), 64'd0);
        chk("rst_fc", 64'(frame_count), 64'd0);
        chk("rst_src", 64'(src_mac), 64'd0);
        chkw("rst_rvvi", rvvi, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rready_pre_edge", 64'(rready), 64'd0);
        @(posedge clk); #1;
        chk("rready_post_edge", 64'(rready), 64'd1);

        // Good frame, consumer ready.
        img = mk_img(LMAC, SRC1, ET, 16'h0007, 8'h11);
        send_frame(img, 0, NW, 1'b1);
        chk("good_valid", 64'(valid), 64'd1);
        chk("good_rready", 64'(rready), 64'd0);
        chk("good_fc", 64'(frame_count), 64'h0007);
        chk("good_src", 64'(src_mac), 64'(SRC1));
        chkw("good_rvvi", rvvi, img[FW-1:128]);
        chk("good_runt", 64'(runt_count), 64'd0);
        chk("good_bad", 64'(bad_count), 64'd0);
        @(posedge clk); #1;
        chk("good_valid_drop", 64'(valid), 64'd0);
        chk("good_rready_back", 64'(rready), 64'd1);

        // Padded frame, consumer stalls for 10 cycles.
        ready = 1'b0;
        img = mk_img(LMAC, SRC1, ET, 16'h0008, 8'h22);
        send_frame(img, 0, 32, 1'b1);
        chk("pad_valid", 64'(valid), 64'd1);
        chk("pad_fc", 64'(frame_count), 64'h0008);
        chkw("pad_rvvi", rvvi, img[FW-1:128]);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_rready", 64'(rready), 64'd0);
            chkw("hold_rvvi", rvvi, img[FW-1:128]);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 64'(valid), 64'd0);
        chk("release_rready", 64'(rready), 64'd1);

        // Destination mismatch: dropped, header outputs untouched.
        img = mk_img(48'h0, SRC2, ET, 16'h0009, 8'h33);
        send_frame(img, 0, NW, 1'b1);
        chk("baddst_count", 64'(bad_count), 64'd1);
        chk("baddst_valid", 64'(valid), 64'd0);
        chk("baddst_fc", 64'(frame_count), 64'h0008);
        chk("baddst_src", 64'(src_mac), 64'(SRC1));

        // Runts: 10 beats, then a single beat.
        img = mk_img(LMAC, SRC1, ET, 16'h000A, 8'h44);
        send_frame(img, 0, 10, 1'b1);
        chk("runt10_count", 64'(runt_count), 64'd1);
        chk("runt10_valid", 64'(valid), 64'd0);
        chk("runt10_bad", 64'(bad_count), 64'd1);
        send_frame(img, 0, 1, 1'b1);
        chk("runt1_count", 64'(runt_count), 64'd2);

        // EtherType mismatch.
        img = mk_img(LMAC, SRC1, 16'h0800, 16'h000A, 8'h45);
        send_frame(img, 0, NW, 1'b1);
        chk("badtype_count", 64'(bad_count), 64'd2);
        chk("badtype_valid", 64'(valid), 64'd0);

        // Good frame after drops.
        img = mk_img(LMAC, SRC2, ET, 16'h0009, 8'h55);
        send_frame(img, 0, NW, 1'b1);
        chk("after_valid", 64'(valid), 64'd1);
        chk("after_fc", 64'(frame_count), 64'h0009);
        chk("after_src", 64'(src_mac), 64'(SRC2));
        chkw("after_rvvi", rvvi, img[FW-1:128]);
        @(posedge clk); #1;

        // Reset at beat 12; the tail carries a valid-looking header so it is a runt.
        img = mk_img(LMAC, SRC1, ET, 16'h000A, 8'h66);
        for (int w = 0; w < 4; w++) img[(w+12)*32 +: 32] = img[w*32 +: 32];
        send_frame(img, 0, 12, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_rready", 64'(rready), 64'd0);
        chk("mid_rst_fc", 64'(frame_count), 64'd0);
        chk("mid_rst_src", 64'(src_mac), 64'd0);
        chk("mid_rst_runt", 64'(runt_count), 64'd0);
        chk("mid_rst_bad", 64'(bad_count), 64'd0);
        chkw("mid_rst_rvvi", rvvi, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(img, 12, NW, 1'b1);
        chk("tail_runt", 64'(runt_count), 64'd1);
        chk("tail_bad", 64'(bad_count), 64'd0);
        chk("tail_valid", 64'(valid), 64'd0);
        img2 = mk_img(LMAC, SRC2, ET, 16'h000B, 8'h77);
        send_frame(img2, 0, NW, 1'b1);
        chk("post_rst_valid", 64'(valid), 64'd1);
        chk("post_rst_fc", 64'(frame_count), 64'h000B);
        chkw("post_rst_rvvi", rvvi, img2[FW-1:128]);
        @(posedge clk); #1;

`ifdef RVVI_DEPKT_SEQCHK_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            img = mk_img(LMAC, SRC1, ET, seq_fc[k], 8'(k));
            send_frame(img, 0, NW, 1'b1);
            chk("seq_err", 64'(seq_err), 64'(seq_exp[k]));
            @(posedge clk); #1;
            chk("seq_err_pulse", 64'(seq_err), 64'd0);
        end
        chk("seq_err_count", 64'(seq_err_count), 64'd2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
